// File: rtl/mul_arbiter_if.sv
// Requester-side bundle for mul_arbiter: request valid/ready channels plus per-requester
// response buffers. Clients use the master modport; the arbiter uses the slave modport.
interface mul_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_sign;
    logic [NREQ*32-1:0]   req_x;
    logic [NREQ*32-1:0]   req_y;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [NREQ*64-1:0]   resp_result;

    modport master (
        output req_valid, req_sign, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_sign, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters, with ID tags and
// one-entry response buffers. Define MUL_ARB_PRIO0_EN to give requester 0 strict priority.
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  bus,
    output logic          mul_sign,
    output logic [31:0]   mul_x,
    output logic [31:0]   mul_y,
    input  logic [63:0]   mul_result
);
    logic [MUL_LAT-1:0] tag_valid;
    logic [IDW-1:0]     tag_id [MUL_LAT];
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     next_ptr;
    logic [NREQ-1:0]    inflight;
    logic [NREQ-1:0]    busy;
    logic [NREQ-1:0]    elig;
    logic               grant;
    logic [IDW-1:0]     grant_id;
    logic [NREQ-1:0]    resp_valid_q;
    logic [63:0]        resp_result_q [NREQ];

    // A requester stays busy from issue until its response has been consumed.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < MUL_LAT; s++) begin
            if (tag_valid[s]) begin
                inflight[tag_id[s]] = 1'b1;
            end
        end
    end

    assign busy = inflight | (resp_valid_q & ~bus.resp_ready);
    assign elig = bus.req_valid & ~busy & {NREQ{~rst}};

    always_comb begin
        int idx;
        grant    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant && elig[idx]) begin
                grant    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
`ifdef MUL_ARB_PRIO0_EN
        if (elig[0]) begin
            grant    = 1'b1;
            grant_id = '0;
        end
`endif
    end

    assign next_ptr      = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign bus.req_ready = grant ? (NREQ'(1) << grant_id) : '0;
    assign mul_sign      = grant ? bus.req_sign[grant_id] : 1'b0;
    assign mul_x         = grant ? bus.req_x[32*grant_id +: 32] : 32'd0;
    assign mul_y         = grant ? bus.req_y[32*grant_id +: 32] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            tag_valid    <= '0;
            resp_valid_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_id[s] <= '0;
            end
            for (int k = 0; k < NREQ; k++) begin
                resp_result_q[k] <= '0;
            end
        end else begin
            if (grant) begin
`ifdef MUL_ARB_PRIO0_EN
                if (grant_id != '0) begin
                    rr_ptr <= next_ptr;
                end
`else
                rr_ptr <= next_ptr;
`endif
            end
            tag_valid[0] <= grant;
            tag_id[0]    <= grant_id;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
            // The busy rule guarantees a completion never meets a pending consume for the same buffer.
            for (int k = 0; k < NREQ; k++) begin
                if (tag_valid[MUL_LAT-1] && (tag_id[MUL_LAT-1] == IDW'(k))) begin
                    resp_valid_q[k]  <= 1'b1;
                    resp_result_q[k] <= mul_result;
                end else if (resp_valid_q[k] && bus.resp_ready[k]) begin
                    resp_valid_q[k]  <= 1'b0;
                end
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_resp
        assign bus.resp_result[64*i +: 64] = resp_result_q[i];
    end
endmodule
